// File: rtl/clock_monitor.sv
// clock_monitor
//   Fast-domain checker for a divided clock. mon_clk is sampled with clk_in
//   through a three-flop chain, every half period is measured in clk_in
//   cycles, and lock is declared after LOCK_CNT consecutive measurements
//   within EXP_HALF +/- TOL. A mismatch after lock, or a stopped mon_clk
//   (counter saturating), sets a sticky fault that only enable=0 or rst
//   clears.
//
//   Optional feature macro: CLK_MON_STATS_EN
//     When defined, min_half / max_half track the extremes of all
//     measurements since the last rst or enable=0.
//
// Ports
//   clk_in        in   1      sole clock, all logic on posedge
//   rst           in   1      synchronous, active-high reset
//   mon_clk       in   1      monitored clock, treated as asynchronous data
//   enable        in   1      0 = idle/clear, 1 = monitor
//   edge_pulse    out  1      one-cycle pulse per mon_clk edge (either polarity)
//   period_valid  out  1      one-cycle pulse, half_period holds a new measurement
//   half_period   out  CNT_W  last full measurement in clk_in cycles
//   locked        out  1      lock achieved, no fault since
//   fault         out  1      sticky mismatch / timeout flag
//   min_half      out  CNT_W  smallest measurement (CLK_MON_STATS_EN only)
//   max_half      out  CNT_W  largest measurement  (CLK_MON_STATS_EN only)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | disabled; counters held at zero
// ST_ACQUIRE | waiting for the first edge; partial interval is discarded
// ST_TRACK   | measuring, counting consecutive good half periods
// ST_LOCKED  | LOCK_CNT good measurements seen; any bad one is a fault
// ST_FAULT   | sticky fault until enable drops or rst

module clock_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_HALF = 10,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             enable,
    output logic             edge_pulse,
    output logic             period_valid,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             fault
`ifdef CLK_MON_STATS_EN
    ,
    output logic [CNT_W-1:0] min_half,
    output logic [CNT_W-1:0] max_half
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // Good window computed one bit wider than the counter so that
    // EXP_HALF + TOL and cnt + 1 never wrap, and the low bound never underflows.
    localparam int LO_I = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam int HI_I = EXP_HALF + TOL;
    localparam logic [CNT_W:0] LO_BOUND = (CNT_W+1)'(LO_I);
    localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(HI_I);
    localparam logic [3:0]     LOCK_TGT = 4'(LOCK_CNT);

    state_t           state;
    state_t           state_nxt;

    logic             sync_s1;
    logic             sync_s2;
    logic             sync_s3;
    logic             edge_det;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_sat;
    logic [3:0]       good_cnt;
    logic [3:0]       good_cnt_nxt;
    logic [3:0]       good_inc;

    logic [CNT_W:0]   meas;
    logic [CNT_W-1:0] meas_clip;
    logic             meas_good;

    logic             pv_nxt;
    logic [CNT_W-1:0] hp_nxt;

    // cnt counts cycles since the last edge, so the interval ending on this
    // edge is one more than the current count.
    assign meas      = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign meas_clip = meas[CNT_W] ? '1 : meas[CNT_W-1:0];
    assign meas_good = (meas >= LO_BOUND) && (meas <= HI_BOUND);
    assign cnt_sat   = &cnt;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign good_inc  = good_cnt + 4'd1;

    assign locked = (state == ST_LOCKED);
    assign fault  = (state == ST_FAULT);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        good_cnt_nxt = good_cnt;
        pv_nxt       = 1'b0;
        hp_nxt       = half_period;

        if (!enable) begin
            state_nxt    = ST_IDLE;
            cnt_nxt      = '0;
            good_cnt_nxt = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt    = ST_ACQUIRE;
                    cnt_nxt      = '0;
                    good_cnt_nxt = '0;
                end

                ST_ACQUIRE: begin
                    if (edge_det) begin
                        state_nxt    = ST_TRACK;
                        cnt_nxt      = '0;
                        good_cnt_nxt = '0;
                    end else if (cnt_sat) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end

                ST_TRACK, ST_LOCKED: begin
                    // An edge in the saturation cycle still counts as an edge.
                    if (edge_det) begin
                        cnt_nxt = '0;
                        pv_nxt  = 1'b1;
                        hp_nxt  = meas_clip;
                        if (meas_good) begin
                            if (state == ST_TRACK) begin
                                good_cnt_nxt = good_inc;
                                if (good_inc == LOCK_TGT) begin
                                    state_nxt = ST_LOCKED;
                                end
                            end
                        end else begin
                            good_cnt_nxt = '0;
                            if (state == ST_LOCKED) begin
                                state_nxt = ST_FAULT;
                            end
                        end
                    end else if (cnt_sat) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end

                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_s1      <= 1'b0;
            sync_s2      <= 1'b0;
            sync_s3      <= 1'b0;
            edge_det     <= 1'b0;
            edge_pulse   <= 1'b0;
            state        <= ST_IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_valid <= 1'b0;
            half_period  <= '0;
        end else begin
            sync_s1      <= mon_clk;
            sync_s2      <= sync_s1;
            sync_s3      <= sync_s2;
            // edge_det is registered so edge_pulse and the FSM outputs that
            // react to the same edge appear together.
            edge_det     <= sync_s2 ^ sync_s3;
            edge_pulse   <= edge_det;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            good_cnt     <= good_cnt_nxt;
            period_valid <= pv_nxt;
            half_period  <= hp_nxt;
        end
    end

`ifdef CLK_MON_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst || !enable) begin
            min_half <= '1;
            max_half <= '0;
        end else if (pv_nxt) begin
            if (hp_nxt < min_half) begin
                min_half <= hp_nxt;
            end
            if (hp_nxt > max_half) begin
                max_half <= hp_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor (EXP_HALF=10, TOL=1, LOCK_CNT=4, CNT_W=8).
module tb_clock_monitor;

    localparam int CNT_W    = 8;
    localparam int EXP_HALF = 10;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int SAT      = 255;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_TRK  = 2;
    localparam int M_LCK  = 3;
    localparam int M_FLT  = 4;

    logic             clk_in  = 1'b0;
    logic             rst     = 1'b1;
    logic             mon_clk = 1'b0;
    logic             enable  = 1'b0;
    logic             edge_pulse;
    logic             period_valid;
    logic [CNT_W-1:0] half_period;
    logic             locked;
    logic             fault;
`ifdef CLK_MON_STATS_EN
    logic [CNT_W-1:0] min_half;
    logic [CNT_W-1:0] max_half;
`endif

    int tests = 0;
    int fails = 0;

    clock_monitor #(
        .CNT_W(CNT_W), .EXP_HALF(EXP_HALF), .TOL(TOL), .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .mon_clk(mon_clk),
        .enable(enable),
        .edge_pulse(edge_pulse),
        .period_valid(period_valid),
        .half_period(half_period),
        .locked(locked),
        .fault(fault)
`ifdef CLK_MON_STATS_EN
        ,
        .min_half(min_half),
        .max_half(max_half)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // mon_clk generator: each toggle starts a half period whose length is
    // taken from halves_q if non-empty, else gen_half (0 = hold mon_clk).
    int gen_half = 0;
    int halves_q[$];

    initial begin
        forever begin
            int h;
            h = (halves_q.size() > 0) ? halves_q.pop_front() : gen_half;
            if (h <= 0) begin
                @(negedge clk_in);
            end else begin
                mon_clk = ~mon_clk;
                repeat (h) @(negedge clk_in);
            end
        end
    end

    // Reference model in terms of time stamps: an edge is recognised three
    // cycles after it was first sampled; a measurement is the number of
    // cycles between two recognised edges, clipped at SAT.
    int mode = M_IDLE;
    int ref_t = 0;
    int good_run = 0;
    int t = 0;
    int m_hp = 0;
    int m_min = SAT;
    int m_max = 0;
    bit m_ep = 0;
    bit m_pv = 0;
    bit samp[4];

    always @(posedge clk_in) begin
        int  el;
        int  meas;
        bit  ev;
        t++;
        if (rst) begin
            samp     = '{default: 1'b0};
            mode     = M_IDLE;
            good_run = 0;
            m_hp     = 0;
            m_ep     = 0;
            m_pv     = 0;
            m_min    = SAT;
            m_max    = 0;
        end else begin
            ev   = (samp[2] != samp[3]);
            m_ep = ev;
            m_pv = 0;
            if (!enable) begin
                mode     = M_IDLE;
                good_run = 0;
                m_min    = SAT;
                m_max    = 0;
            end else if (mode == M_IDLE) begin
                mode  = M_ACQ;
                ref_t = t;
            end else if (mode != M_FLT) begin
                el = t - 1 - ref_t;
                if (el > SAT) el = SAT;
                if (ev) begin
                    if (mode == M_ACQ) begin
                        mode     = M_TRK;
                        good_run = 0;
                    end else begin
                        meas = el + 1;
                        m_pv = 1;
                        m_hp = (meas > SAT) ? SAT : meas;
                        if (m_hp < m_min) m_min = m_hp;
                        if (m_hp > m_max) m_max = m_hp;
                        if (meas >= EXP_HALF - TOL && meas <= EXP_HALF + TOL) begin
                            good_run++;
                            if (good_run >= LOCK_CNT) mode = M_LCK;
                        end else begin
                            good_run = 0;
                            if (mode == M_LCK) mode = M_FLT;
                        end
                    end
                    ref_t = t;
                end else if (el == SAT) begin
                    mode = M_FLT;
                end
            end
            samp[3] = samp[2];
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = mon_clk;
        end
    end

    always @(negedge clk_in) begin
        logic [11:0] act_v;
        logic [11:0] exp_v;
        act_v = {edge_pulse, period_valid, half_period, locked, fault};
        exp_v = {m_ep, m_pv, 8'(m_hp), mode == M_LCK, mode == M_FLT};
        check("model_outputs", {52'd0, act_v}, {52'd0, exp_v});
`ifdef CLK_MON_STATS_EN
        check("model_stats", {48'd0, min_half, max_half}, {48'd0, 8'(m_min), 8'(m_max)});
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic restart(input int h);
        enable   = 1'b0;
        gen_half = 0;
        tick(30);
        enable   = 1'b1;
        gen_half = h;
    endtask

    task automatic wait_lock(input int budget, output int pvs, output int eps, output bit ok);
        pvs = 0;
        eps = 0;
        ok  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (edge_pulse) eps++;
            if (period_valid) pvs++;
            if (locked) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_pv(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (period_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_fault(input int budget, output int since_edge, output bit ok);
        ok = 0;
        since_edge = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (edge_pulse) since_edge = 0;
            else since_edge++;
            if (fault) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int pvs;
        int eps;
        int since;
        bit ok;
        int opts[9] = '{1, 2, 5, 8, 9, 10, 11, 12, 13};

        // Reset state
        tick(3);
        check("reset_outputs", {edge_pulse, period_valid, half_period, locked, fault}, 0);
        rst = 1'b0;
        tick(2);

        // 1: steady half period 10, lock on 4th period_valid / 5th edge
        enable   = 1'b1;
        gen_half = 10;
        wait_lock(200, pvs, eps, ok);
        check("t1_lock_seen", ok, 1);
        check("t1_pv_count", pvs, 4);
        check("t1_edge_count", eps, 5);
        check("t1_half", half_period, 10);
        check("t1_fault", fault, 0);
        check("t1_model_hp", m_hp, 10);
        check("t1_model_locked", mode, M_LCK);

        // 2: half period 11 locks; 12 never locks
        restart(11);
        wait_lock(200, pvs, eps, ok);
        check("t2_lock11_seen", ok, 1);
        check("t2_lock11_pv", pvs, 4);
        check("t2_lock11_half", half_period, 11);
        restart(12);
        wait_pv(100, ok);
        check("t2_pv12_seen", ok, 1);
        check("t2_half12", half_period, 12);
        tick(120);
        check("t2_no_lock12", locked, 0);
        check("t2_no_fault12", fault, 0);

        // 3: stop mon_clk after lock -> fault 256 cycles after the last edge
        restart(10);
        wait_lock(200, pvs, eps, ok);
        check("t3_lock_seen", ok, 1);
        gen_half = 0;
        wait_fault(400, since, ok);
        check("t3_fault_seen", ok, 1);
        check("t3_fault_delay", since, 256);
        check("t3_unlocked", locked, 0);

        // 4: one short half period after lock
        restart(10);
        wait_lock(200, pvs, eps, ok);
        check("t4_lock_seen", ok, 1);
        halves_q.push_back(5);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_in);
            if (period_valid && half_period != 8'd10) begin
                ok = 1;
                break;
            end
        end
        check("t4_short_seen", ok, 1);
        check("t4_short_half", half_period, 5);
        check("t4_fault_same_cycle", fault, 1);
        check("t4_unlocked", locked, 0);
        tick(80);
        check("t4_fault_sticky", fault, 1);

        // 5: rst mid-TRACK, enable=0 while FAULT, relock
        restart(10);
        wait_pv(60, ok);
        wait_pv(60, ok);
        check("t5_in_track", {ok, locked}, 2'b10);
        rst = 1'b1;
        tick(1);
        check("t5_rst_outputs", {edge_pulse, period_valid, half_period, locked, fault}, 0);
        rst = 1'b0;
        wait_lock(200, pvs, eps, ok);
        check("t5_relock_after_rst", ok, 1);
        halves_q.push_back(5);
        wait_fault(80, since, ok);
        check("t5_fault_seen", ok, 1);
        enable = 1'b0;
        tick(1);
        check("t5_disable_flags", {locked, fault}, 0);
        check("t5_half_retained", half_period, 5);
        enable = 1'b1;
        wait_lock(200, pvs, eps, ok);
        check("t5_relock_seen", ok, 1);
        check("t5_relock_pv", pvs, 4);

`ifdef CLK_MON_STATS_EN
        // 6: min/max over 9,10,11,10 and re-init on enable=0
        restart(10);
        halves_q.push_back(9);
        halves_q.push_back(10);
        halves_q.push_back(11);
        halves_q.push_back(10);
        for (int i = 0; i < 4; i++) wait_pv(60, ok);
        check("t6_min", min_half, 9);
        check("t6_max", max_half, 11);
        enable = 1'b0;
        tick(1);
        check("t6_min_init", min_half, 255);
        check("t6_max_init", max_half, 0);
        enable = 1'b1;
`endif

        // Randomised phase, checked cycle by cycle against the model
        for (int it = 0; it < 160; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end else if (r < 14) begin
                enable = 1'b0;
                tick($urandom_range(1, 4));
                enable = 1'b1;
            end else if (r < 17) begin
                gen_half = 0;
                tick(300);
            end else if (r < 25) begin
                halves_q.push_back(opts[$urandom_range(0, 8)]);
            end else if ($urandom_range(0, 9) < 7) begin
                gen_half = $urandom_range(9, 11);
            end else begin
                gen_half = opts[$urandom_range(0, 8)];
            end
            tick($urandom_range(20, 120));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
